// File: rtl/out_vc_credit_ctrl_pkg.sv
// Shared flit-format constants for the router datapath and output-port control.
package out_vc_credit_ctrl_pkg;

   localparam int FLIT_SIZE  = 32;
   localparam int HEADER_LEN = 2;

   typedef enum logic [HEADER_LEN-1:0] {
      HEAD_FLIT   = 2'd0,
      BODY_FLIT   = 2'd1,
      TAIL_FLIT   = 2'd2,
      SINGLE_FLIT = 2'd3
   } flit_type_e;

   // A packet gives up its VC when its final flit leaves.
   function automatic logic is_last_flit(input logic [HEADER_LEN-1:0] ftype);
      return (ftype == TAIL_FLIT) || (ftype == SINGLE_FLIT);
   endfunction

endpackage

// File: rtl/out_vc_credit_ctrl_if.sv
// Allocation, send, link and credit signals between an output port controller and its neighbours.
interface out_vc_credit_ctrl_if
   import out_vc_credit_ctrl_pkg::*;
#(
   parameter int NUM_VC    = 4,
   parameter int VC_SIZE   = 4,
   parameter int FLIT_W    = out_vc_credit_ctrl_pkg::FLIT_SIZE,
   parameter int IN_ID_W   = 4
);
   localparam int VC_W = $clog2(NUM_VC);
   localparam int CW   = $clog2(VC_SIZE + 1);

   logic                      alloc_req;
   logic [IN_ID_W-1:0]        alloc_in_id;
   logic                      alloc_gnt;
   logic [VC_W-1:0]           alloc_vc;

   logic                      send_valid;
   logic [VC_W-1:0]           send_vc;
   logic [FLIT_W-1:0]         send_flit;

   logic                      link_valid;
   logic [VC_W-1:0]           link_vc;
   logic [FLIT_W-1:0]         link_flit;

   logic                      credit_valid;
   logic [VC_W-1:0]           credit_vc;
   logic [NUM_VC*CW-1:0]      credit_cnt;

   logic [NUM_VC-1:0]         vc_busy;
   logic [NUM_VC*IN_ID_W-1:0] vc_owner;
   logic                      err;

   modport master (
      output alloc_req, alloc_in_id, send_valid, send_vc, send_flit,
             credit_valid, credit_vc,
      input  alloc_gnt, alloc_vc, link_valid, link_vc, link_flit,
             credit_cnt, vc_busy, vc_owner, err
   );

   modport slave (
      input  alloc_req, alloc_in_id, send_valid, send_vc, send_flit,
             credit_valid, credit_vc,
      output alloc_gnt, alloc_vc, link_valid, link_vc, link_flit,
             credit_cnt, vc_busy, vc_owner, err
   );

endinterface

// File: rtl/out_vc_credit_ctrl_rr_arbiter.sv
// Combinational rotating-priority arbiter: first requester at or after i_ptr wins.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   int w_cand;

   always_comb begin
      o_gnt  = '0;
      o_idx  = '0;
      o_any  = 1'b0;
      w_cand = 0;
      for (int k = 0; k < N; k++) begin
         w_cand = (int'(i_ptr) + k) % N;
         if (!o_any && i_req[w_cand]) begin
            o_any         = 1'b1;
            o_gnt[w_cand] = 1'b1;
            o_idx         = IW'(w_cand);
         end
      end
   end

endmodule

// File: rtl/out_vc_credit_ctrl.sv
// Upstream side of one output port: VC allocation, per-VC credit tracking,
// link register and VC release on the last flit of a packet.
module out_vc_credit_ctrl
   import out_vc_credit_ctrl_pkg::*;
#(
   parameter int NUM_VC  = 4,
   parameter int VC_SIZE = 4,
   parameter int IN_ID_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   out_vc_credit_ctrl_if.slave  bus
);

   localparam int VC_W = $clog2(NUM_VC);
   localparam int CW   = $clog2(VC_SIZE + 1);
   localparam logic [CW-1:0] FULL_CREDIT = CW'(VC_SIZE);

   logic                      r_alloc_gnt;
   logic [VC_W-1:0]           r_alloc_vc;
   logic [VC_W-1:0]           r_rr_ptr;
   logic                      r_link_valid;
   logic [VC_W-1:0]           r_link_vc;
   logic [FLIT_SIZE-1:0]      r_link_flit;
   logic                      r_err;

   logic [NUM_VC-1:0]         w_busy;
   logic [NUM_VC*CW-1:0]      w_credit_flat;
   logic [NUM_VC*IN_ID_W-1:0] w_owner_flat;
   logic [NUM_VC-1:0]         w_sat;

   logic [NUM_VC-1:0]         w_arb_gnt;
   logic [VC_W-1:0]           w_arb_idx;
   logic                      w_arb_any;
   logic                      w_alloc_fire;

   logic                      w_send_busy;
   logic                      w_credit_same;
   logic                      w_send_has_credit;
   logic                      w_send_ok;
   logic                      w_release;
   logic                      w_err_event;

   // Credits never gate allocation: only ownership matters here.
   rr_arbiter #(
      .N  (NUM_VC),
      .IW (VC_W)
   ) u_rr_arbiter (
      .i_req (~w_busy),
      .i_ptr (r_rr_ptr),
      .o_gnt (w_arb_gnt),
      .o_idx (w_arb_idx),
      .o_any (w_arb_any)
   );

   assign w_alloc_fire = bus.alloc_req && !r_alloc_gnt && w_arb_any;

   // A credit arriving on the same VC in the same cycle covers a send at zero.
   assign w_send_busy       = w_busy[bus.send_vc];
   assign w_credit_same     = bus.credit_valid && (bus.credit_vc == bus.send_vc);
   assign w_send_has_credit = (w_credit_flat[bus.send_vc*CW +: CW] != '0) || w_credit_same;
   assign w_send_ok         = bus.send_valid && w_send_busy && w_send_has_credit;
   assign w_release         = w_send_ok && is_last_flit(bus.send_flit[FLIT_SIZE-1 -: HEADER_LEN]);

   assign w_err_event = (bus.send_valid && !w_send_busy)
                     || (bus.send_valid && w_send_busy && !w_send_has_credit)
                     || (|w_sat);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_VC; gi++) begin : g_vc
         logic [CW-1:0]      r_credit;
         logic               r_busy;
         logic [IN_ID_W-1:0] r_owner;
         logic               w_inc;
         logic               w_dec;

         assign w_inc     = bus.credit_valid && (bus.credit_vc == VC_W'(gi));
         assign w_dec     = w_send_ok && (bus.send_vc == VC_W'(gi));
         assign w_sat[gi] = w_inc && !w_dec && (r_credit == FULL_CREDIT);

         always_ff @(posedge clk) begin
            if (rst) begin
               r_credit <= FULL_CREDIT;
               r_busy   <= 1'b0;
               r_owner  <= '0;
            end else begin
               if (w_inc && !w_dec && !w_sat[gi])
                  r_credit <= r_credit + CW'(1);
               else if (w_dec && !w_inc)
                  r_credit <= r_credit - CW'(1);

               // The allocator only picks free VCs, so it never collides with a release.
               if (w_alloc_fire && w_arb_gnt[gi]) begin
                  r_busy  <= 1'b1;
                  r_owner <= bus.alloc_in_id;
               end else if (w_release && (bus.send_vc == VC_W'(gi))) begin
                  r_busy  <= 1'b0;
               end
            end
         end

         assign w_credit_flat[gi*CW +: CW]           = r_credit;
         assign w_owner_flat[gi*IN_ID_W +: IN_ID_W]  = r_owner;
         assign w_busy[gi]                           = r_busy;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_alloc_gnt  <= 1'b0;
         r_alloc_vc   <= '0;
         r_rr_ptr     <= '0;
         r_link_valid <= 1'b0;
         r_link_vc    <= '0;
         r_link_flit  <= '0;
         r_err        <= 1'b0;
      end else begin
         r_alloc_gnt <= w_alloc_fire;
         if (w_alloc_fire) begin
            r_alloc_vc <= w_arb_idx;
            r_rr_ptr   <= (w_arb_idx == VC_W'(NUM_VC - 1)) ? '0 : w_arb_idx + VC_W'(1);
         end

         r_link_valid <= w_send_ok;
         if (w_send_ok) begin
            r_link_vc   <= bus.send_vc;
            r_link_flit <= bus.send_flit;
         end

         r_err <= r_err || w_err_event;
      end
   end

   assign bus.alloc_gnt  = r_alloc_gnt;
   assign bus.alloc_vc   = r_alloc_vc;
   assign bus.link_valid = r_link_valid;
   assign bus.link_vc    = r_link_vc;
   assign bus.link_flit  = r_link_flit;
   assign bus.credit_cnt = w_credit_flat;
   assign bus.vc_busy    = w_busy;
   assign bus.vc_owner   = w_owner_flat;
   assign bus.err        = r_err;

endmodule

// File: tb/tb_out_vc_credit_ctrl.sv
// Directed test of out_vc_credit_ctrl: allocation, credit flow, errors and mid-run reset.
module tb_out_vc_credit_ctrl;
   import out_vc_credit_ctrl_pkg::*;

   localparam int NUM_VC  = 4;
   localparam int VC_SIZE = 4;
   localparam int IN_ID_W = 4;
   localparam int CW      = 3;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   out_vc_credit_ctrl_if #(
      .NUM_VC  (NUM_VC),
      .VC_SIZE (VC_SIZE),
      .IN_ID_W (IN_ID_W)
   ) bus ();

   out_vc_credit_ctrl #(
      .NUM_VC  (NUM_VC),
      .VC_SIZE (VC_SIZE),
      .IN_ID_W (IN_ID_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec  = 0;
   int n_miss = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %-14s got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end else begin
         $display("ok   %-14s = %0h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.alloc_req    = 1'b0;
      bus.alloc_in_id  = '0;
      bus.send_valid   = 1'b0;
      bus.send_vc      = '0;
      bus.send_flit    = '0;
      bus.credit_valid = 1'b0;
      bus.credit_vc    = '0;
   endtask

   task automatic send(input logic [1:0] vc, input logic [31:0] flit);
      bus.send_valid = 1'b1;
      bus.send_vc    = vc;
      bus.send_flit  = flit;
   endtask

   function automatic logic [31:0] mk(input logic [1:0] ftype, input logic [29:0] payload);
      return {ftype, payload};
   endfunction

   function automatic logic [CW-1:0] cred(input int v);
      return bus.credit_cnt[v*CW +: CW];
   endfunction

   function automatic logic [IN_ID_W-1:0] owner(input int v);
      return bus.vc_owner[v*IN_ID_W +: IN_ID_W];
   endfunction

   flit_type_e  t3 [4];
   logic [31:0] f;

   initial begin
      t3[0] = HEAD_FLIT;
      t3[1] = BODY_FLIT;
      t3[2] = BODY_FLIT;
      t3[3] = BODY_FLIT;

      idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check_eq("rst_credits", bus.credit_cnt, 12'h924);
      check_eq("rst_busy",    bus.vc_busy, 4'b0000);
      check_eq("rst_gnt",     bus.alloc_gnt, 1'b0);
      check_eq("rst_link_v",  bus.link_valid, 1'b0);
      check_eq("rst_err",     bus.err, 1'b0);
      check_eq("rst_owner",   bus.vc_owner, 16'h0000);

      // First grant, one cycle after the request
      bus.alloc_req   = 1'b1;
      bus.alloc_in_id = 4'd5;
      tick();
      check_eq("g0_gnt",   bus.alloc_gnt, 1'b1);
      check_eq("g0_vc",    bus.alloc_vc, 2'd0);
      check_eq("g0_busy",  bus.vc_busy, 4'b0001);
      check_eq("g0_owner", owner(0), 4'd5);
      check_eq("g0_cred",  bus.credit_cnt, 12'h924);

      // Held request: grants on alternate cycles
      bus.alloc_in_id = 4'd6;
      tick();
      check_eq("g1_gap", bus.alloc_gnt, 1'b0);
      tick();
      check_eq("g1_gnt", bus.alloc_gnt, 1'b1);
      check_eq("g1_vc",  bus.alloc_vc, 2'd1);
      bus.alloc_in_id = 4'd7;
      tick();
      tick();
      check_eq("g2_vc",  bus.alloc_vc, 2'd2);
      check_eq("g2_gnt", bus.alloc_gnt, 1'b1);
      bus.alloc_in_id = 4'd8;
      tick();
      tick();
      check_eq("g3_vc",    bus.alloc_vc, 2'd3);
      check_eq("g3_busy",  bus.vc_busy, 4'b1111);
      check_eq("g3_owner", owner(3), 4'd8);
      bus.alloc_in_id = 4'd9;
      tick();
      tick();
      check_eq("g4_pend", bus.alloc_gnt, 1'b0);

      // TAIL on VC2 frees it; the pending request takes it one cycle later
      f = mk(TAIL_FLIT, 30'h2A2A);
      send(2'd2, f);
      tick();
      check_eq("rel_busy",  bus.vc_busy, 4'b1011);
      check_eq("rel_gnt",   bus.alloc_gnt, 1'b0);
      check_eq("rel_lnk_v", bus.link_valid, 1'b1);
      check_eq("rel_lnk_c", bus.link_vc, 2'd2);
      check_eq("rel_flit",  bus.link_flit, f);
      bus.send_valid = 1'b0;
      tick();
      check_eq("g4_gnt",   bus.alloc_gnt, 1'b1);
      check_eq("g4_vc",    bus.alloc_vc, 2'd2);
      check_eq("g4_owner", owner(2), 4'd9);
      bus.alloc_req = 1'b0;

      // Drain VC1 to zero credits
      for (int i = 0; i < 4; i++) begin
         f = mk(BODY_FLIT, 30'h100 + 30'(i));
         send(2'd1, f);
         tick();
         check_eq("v1_lnk_v", bus.link_valid, 1'b1);
         check_eq("v1_flit",  bus.link_flit, f);
      end
      bus.send_valid = 1'b0;
      check_eq("v1_cred0", cred(1), 3'd0);

      // Send and credit together at zero: forwarded, count unchanged
      f = mk(BODY_FLIT, 30'h1FF);
      send(2'd1, f);
      bus.credit_valid = 1'b1;
      bus.credit_vc    = 2'd1;
      tick();
      check_eq("sc_lnk_v", bus.link_valid, 1'b1);
      check_eq("sc_flit",  bus.link_flit, f);
      check_eq("sc_cred",  cred(1), 3'd0);
      check_eq("sc_err",   bus.err, 1'b0);
      idle();

      // Credits: normal return, then saturation
      bus.credit_valid = 1'b1;
      bus.credit_vc    = 2'd2;
      tick();
      check_eq("cr2_cred", cred(2), 3'd4);
      check_eq("cr2_err",  bus.err, 1'b0);
      bus.credit_vc = 2'd3;
      tick();
      check_eq("sat_cred", cred(3), 3'd4);
      check_eq("sat_err",  bus.err, 1'b1);
      idle();

      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("rst2_err", bus.err, 1'b0);

      // VC0: four sends exhaust credit, fifth is dropped
      bus.alloc_req   = 1'b1;
      bus.alloc_in_id = 4'd3;
      tick();
      check_eq("a0_vc", bus.alloc_vc, 2'd0);
      bus.alloc_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         f = mk(t3[i], 30'h300 + 30'(i));
         send(2'd0, f);
         tick();
         check_eq("v0_lnk_v", bus.link_valid, 1'b1);
         check_eq("v0_lnk_c", bus.link_vc, 2'd0);
         check_eq("v0_flit",  bus.link_flit, f);
      end
      check_eq("v0_cred0", cred(0), 3'd0);
      check_eq("v0_err0",  bus.err, 1'b0);
      send(2'd0, mk(BODY_FLIT, 30'h3FF));
      tick();
      check_eq("drop_lnk_v", bus.link_valid, 1'b0);
      check_eq("drop_err",   bus.err, 1'b1);
      check_eq("drop_cred",  cred(0), 3'd0);

      // Send to an unowned VC is dropped
      send(2'd2, mk(SINGLE_FLIT, 30'h222));
      tick();
      check_eq("nb_lnk_v", bus.link_valid, 1'b0);
      check_eq("nb_err",   bus.err, 1'b1);
      check_eq("nb_cred",  cred(2), 3'd4);
      check_eq("nb_busy",  bus.vc_busy, 4'b0001);
      bus.send_valid = 1'b0;

      // Build VC0/VC1 busy with one credit each, then reset mid-operation
      bus.alloc_req   = 1'b1;
      bus.alloc_in_id = 4'd4;
      tick();
      check_eq("a1_vc", bus.alloc_vc, 2'd1);
      bus.alloc_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         send(2'd1, mk(BODY_FLIT, 30'h400 + 30'(i)));
         tick();
      end
      bus.send_valid = 1'b0;
      check_eq("m_cred1", cred(1), 3'd1);
      bus.credit_valid = 1'b1;
      bus.credit_vc    = 2'd0;
      tick();
      bus.credit_valid = 1'b0;
      check_eq("m_cred0", cred(0), 3'd1);
      check_eq("m_busy",  bus.vc_busy, 4'b0011);

      rst             = 1'b1;
      bus.alloc_req   = 1'b1;
      bus.alloc_in_id = 4'd2;
      send(2'd1, mk(BODY_FLIT, 30'h4FF));
      tick();
      check_eq("mr_busy",  bus.vc_busy, 4'b0000);
      check_eq("mr_cred",  bus.credit_cnt, 12'h924);
      check_eq("mr_err",   bus.err, 1'b0);
      check_eq("mr_lnk_v", bus.link_valid, 1'b0);
      check_eq("mr_gnt",   bus.alloc_gnt, 1'b0);
      rst            = 1'b0;
      bus.send_valid = 1'b0;
      tick();
      check_eq("pr_gnt",   bus.alloc_gnt, 1'b1);
      check_eq("pr_vc",    bus.alloc_vc, 2'd0);
      check_eq("pr_owner", owner(0), 4'd2);
      idle();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/out_vc_credit_ctrl.md
Name: out_vc_credit_ctrl

Overview:
Upstream-side controller for one router output port. It is the counterpart of the input VC buffer at the downstream router.
- Allocates downstream virtual channels to requesting input VCs.
- Tracks per-VC credits (free downstream buffer slots).
- Registers outgoing flits onto the link.
- Frees a VC when its tail or single flit departs.

Parameters:
NUM_VC, 4, number of downstream virtual channels on this port
VC_SIZE, 4, downstream VC buffer depth; initial and maximum credit count
FLIT_SIZE, 32, flit width in bits
HEADER_LEN, 2, flit type field width, located at flit[FLIT_SIZE-1 -: HEADER_LEN]
IN_ID_W, 4, width of the requesting input-VC identifier
VC_W, $clog2(NUM_VC), derived, VC index width
CW, $clog2(VC_SIZE+1), derived, credit counter width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
alloc_req  in  1  input VC requests an output VC; held until alloc_gnt
alloc_in_id  in  IN_ID_W  identifier of the requester
alloc_gnt  out  1  one-cycle pulse: allocation done
alloc_vc  out  VC_W  VC granted; valid with alloc_gnt
send_valid  in  1  flit departs switch toward this port
send_vc  in  VC_W  output VC of departing flit
send_flit  in  FLIT_SIZE  departing flit
link_valid  out  1  registered link valid
link_vc  out  VC_W  registered link VC
link_flit  out  FLIT_SIZE  registered link flit
credit_valid  in  1  credit returned by downstream
credit_vc  in  VC_W  VC of the returned credit
credit_cnt  out  NUM_VC*CW  per-VC credits; VC i at [i*CW +: CW]
vc_busy  out  NUM_VC  VC owned by a packet
vc_owner  out  NUM_VC*IN_ID_W  owner id per VC
err  out  1  sticky protocol error

Behaviour:
Reset values:
- credit_cnt: every VC = VC_SIZE.
- vc_busy, alloc_gnt, link_valid, err: 0.
- vc_owner, link_vc, link_flit: 0.
- Round-robin pointer rr_ptr: 0.

Allocation:
- Evaluated when alloc_req=1 and alloc_gnt=0.
- Search order is rotating, starting at rr_ptr; the first VC with vc_busy=0 wins.
- Credit count does not gate allocation.
- On a win, at the clock edge:
  - vc_busy[v] <= 1, vc_owner[v] <= alloc_in_id.
  - alloc_gnt <= 1 and alloc_vc <= v.
  - rr_ptr <= v+1, modulo NUM_VC.
- Latency is 1 cycle.
- alloc_gnt is a single-cycle pulse; a request seen while alloc_gnt=1 is ignored. Maximum rate is one grant per 2 cycles.
- If no VC is free, there is no grant and the request stays pending.

Send:
- When send_valid=1 and VC s=send_vc is busy with credit_cnt[s]>0:
  - credit_cnt[s] decrements.
  - link_valid/link_vc/link_flit register the flit. Link latency is 1 cycle.
- Flit type is decoded from the header field using the package constants.
- If the type is TAIL or SINGLE, vc_busy[s] clears at the same edge.
- A freed VC is allocatable from the next cycle. There is no same-cycle bypass.
- link_valid=0 in any cycle without an accepted send.

Credits:
- credit_valid increments credit_cnt[credit_vc].

Simultaneous events:
- Send and credit on the same VC in the same cycle: net count unchanged. The send is accepted even if the count was 0.
- Release and allocation in the same cycle: the allocator sees the pre-edge vc_busy.

Errors (err set and held until rst):
- Send to a VC with 0 credits and no same-cycle credit: flit dropped, link_valid=0, count unchanged.
- Send to a VC with vc_busy=0: flit dropped.
- Credit that would exceed VC_SIZE: count saturates at VC_SIZE.

Reset mid-operation:
- All VCs are freed and credits restored in the same edge.
- A pending request is re-evaluated after rst deasserts.

Decomposition:
- Shared package (para): FLIT_SIZE, HEADER_LEN, and the HEAD_FLIT, BODY_FLIT, TAIL_FLIT, SINGLE_FLIT encodings.
- Sub-module rr_arbiter:
  - Inputs: NUM_VC request vector and pointer.
  - Outputs: one-hot grant and index.
  - Combinational, reused by the switch allocator.
- Credit counters and link register stay in this module.

Test Plan:
1. Reset, then alloc_req with id=5 -> the next cycle alloc_gnt=1, alloc_vc=0, vc_busy=0001, vc_owner[0]=5; credit_cnt all 4.
2. Four requests on a fully free port -> grants VC 0,1,2,3 on alternate cycles. A fifth request pends until a TAIL is sent on VC2, then grants VC2 one cycle after the release.
3. On VC0: HEAD, BODY, BODY, BODY sent with no credits returned -> credit_cnt[0]=0 and link_flit matches each send one cycle later. A fifth send -> dropped, link_valid=0, err=1.
4. VC1 at credit 0, send and credit_valid on VC1 in the same cycle -> flit forwarded, credit_cnt[1] stays 0, err=0.
5. credit_valid on VC3 while credit_cnt[3]=4 -> count stays 4, err=1. Send on non-busy VC2 -> dropped, err stays 1.
6. rst asserted with VC0/VC1 busy and credits at 1 -> the next cycle vc_busy=0, all credits=4, err=0, link_valid=0.
